// File: rtl/popcount_tnn_sched.sv
// rtl/popcount_tnn_sched.sv - round-robin sequencer sharing one popcount34 unit across ternary neurons
//
// Purpose:
//   Grants a single external 34-input popcount unit to one of NREQ requesters
//   at a time (round robin), streams that requester's activation beats into
//   the unit, accumulates the per-beat counts into a neuron sum and thresholds
//   the sum into a trit returned over a valid/ready result channel.
//
// Optional feature:
//   POPCOUNT_TNN_SCHED_SAT_EN - when defined, the accumulator and the final
//   sum saturate at 2^ACC_W-1; when undefined they wrap modulo 2^ACC_W.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   req_valid/ready/last   per-requester beat handshake and end-of-packet
//   req_data               34 bits per requester, requester i at [34i+33:34i]
//   thr_pos, thr_neg       unsigned thresholds, latched at grant time
//   pc_a                   registered operand to the external popcount unit
//   pc_cnt                 combinational popcount of pc_a
//   res_valid/ready        result handshake
//   res_id, res_sum        owning requester and accumulated count
//   res_trit               01 = +1, 11 = -1, 00 = 0

module popcount_tnn_sched #(
    parameter int NREQ  = 4,
    parameter int ACC_W = 10,
    parameter int ID_W  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [34*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]      req_last,
    input  logic [ACC_W-1:0]     thr_pos,
    input  logic [ACC_W-1:0]     thr_neg,
    output logic [33:0]          pc_a,
    input  logic [5:0]           pc_cnt,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ID_W-1:0]      res_id,
    output logic [ACC_W-1:0]     res_sum,
    output logic [1:0]           res_trit
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        EMIT  = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [ID_W-1:0]    gnt;
    logic [ID_W-1:0]    rr_ptr;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   thr_pos_q;
    logic [ACC_W-1:0]   thr_neg_q;

    logic               any_valid;
    logic [ID_W-1:0]    pick;
    logic [ID_W-1:0]    gnt_inc;
    logic [33:0]        beat;
    logic               beat_acc;
    logic [ACC_W-1:0]   acc_next;
    logic [1:0]         trit_next;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        any_valid = 1'b0;
        pick      = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                pick      = ID_W'(idx);
            end
        end
    end

    assign gnt_inc  = (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
    assign beat     = req_data[34*gnt +: 34];
    // Ready depends only on state and gnt, so beat acceptance is just valid in RUN.
    assign beat_acc = (state_q == RUN) && req_valid[gnt];

    // Accumulator update; pc_cnt always reflects the operand loaded one cycle earlier.
`ifdef POPCOUNT_TNN_SCHED_SAT_EN
    logic [ACC_W:0] sum_wide;
    always_comb begin
        sum_wide = {1'b0, acc} + {{(ACC_W-5){1'b0}}, pc_cnt};
        acc_next = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    end
`else
    always_comb begin
        acc_next = acc + {{(ACC_W-6){1'b0}}, pc_cnt};
    end
`endif

    // Positive threshold wins when both comparisons hold.
    always_comb begin
        trit_next = 2'b00;
        if (acc_next >= thr_pos_q) begin
            trit_next = 2'b01;
        end else if (acc_next <= thr_neg_q) begin
            trit_next = 2'b11;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                req_ready[gnt] = 1'b1;
                if (beat_acc && req_last[gnt]) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = EMIT;
            end
            EMIT: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign res_valid = (state_q == EMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt       <= '0;
            rr_ptr    <= '0;
            acc       <= '0;
            thr_pos_q <= '0;
            thr_neg_q <= '0;
            pc_a      <= '0;
            res_id    <= '0;
            res_sum   <= '0;
            res_trit  <= 2'b00;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    pc_a <= '0;
                    if (any_valid) begin
                        gnt       <= pick;
                        acc       <= '0;
                        thr_pos_q <= thr_pos;
                        thr_neg_q <= thr_neg;
                    end
                end
                RUN: begin
                    // A bubble cycle loads zero so it adds nothing next cycle.
                    pc_a <= beat_acc ? beat : 34'd0;
                    acc  <= acc_next;
                end
                DRAIN: begin
                    acc      <= acc_next;
                    res_sum  <= acc_next;
                    res_id   <= gnt;
                    res_trit <= trit_next;
                    pc_a     <= '0;
                    rr_ptr   <= gnt_inc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_tnn_sched.sv
// tb/tb_popcount_tnn_sched.sv - directed self-checking bench for popcount_tnn_sched
module tb_popcount_tnn_sched;

    localparam int NREQ  = 4;
    localparam int ACC_W = 10;
    localparam int ID_W  = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [34*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [ACC_W-1:0]   thr_pos;
    logic [ACC_W-1:0]   thr_neg;
    logic [33:0]        pc_a;
    logic [5:0]         pc_cnt;
    logic               res_valid;
    logic               res_ready;
    logic [ID_W-1:0]    res_id;
    logic [ACC_W-1:0]   res_sum;
    logic [1:0]         res_trit;

    // Narrow instance for the accumulator overflow case.
    logic [1:0]  req_valid6;
    logic [1:0]  req_ready6;
    logic [67:0] req_data6;
    logic [1:0]  req_last6;
    logic [5:0]  thr_pos6;
    logic [5:0]  thr_neg6;
    logic [33:0] pc_a6;
    logic [5:0]  pc_cnt6;
    logic        res_valid6;
    logic        res_ready6;
    logic [0:0]  res_id6;
    logic [5:0]  res_sum6;
    logic [1:0]  res_trit6;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign pc_cnt  = 6'($countones(pc_a));
    assign pc_cnt6 = 6'($countones(pc_a6));

    popcount_tnn_sched #(.NREQ(NREQ), .ACC_W(ACC_W), .ID_W(ID_W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_last(req_last),
        .thr_pos(thr_pos), .thr_neg(thr_neg),
        .pc_a(pc_a), .pc_cnt(pc_cnt),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_sum(res_sum), .res_trit(res_trit)
    );

    popcount_tnn_sched #(.NREQ(2), .ACC_W(6), .ID_W(1)) u_dut6 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid6), .req_ready(req_ready6), .req_data(req_data6), .req_last(req_last6),
        .thr_pos(thr_pos6), .thr_neg(thr_neg6),
        .pc_a(pc_a6), .pc_cnt(pc_cnt6),
        .res_valid(res_valid6), .res_ready(res_ready6),
        .res_id(res_id6), .res_sum(res_sum6), .res_trit(res_trit6)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic put_beat(input int id, input logic [33:0] d, input logic l, output int waits);
        req_valid[id]          = 1'b1;
        req_data[34*id +: 34]  = d;
        req_last[id]           = l;
        waits = 0;
        while (!req_ready[id] && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        check($sformatf("beat_ready_r%0d", id), req_ready[id], 1);
        @(negedge clk);
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
    endtask

    task automatic get_result(input string tag, input int id, input int sum, input logic [1:0] trit);
        int n = 0;
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, res_valid, 1);
        check({tag, "_id"}, res_id, id);
        check({tag, "_sum"}, res_sum, sum);
        check({tag, "_trit"}, res_trit, trit);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    // Entered in the DRAIN cycle right after the last beat was accepted.
    task automatic finish_pkt(input string tag, input int id, input int sum, input logic [1:0] trit);
        check({tag, "_lat_t1"}, res_valid, 0);
        @(negedge clk);
        check({tag, "_lat_t2"}, res_valid, 1);
        get_result(tag, id, sum, trit);
    endtask

    task automatic wait_grant(input string tag, input logic [NREQ-1:0] exp);
        int n = 0;
        while (req_ready == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, req_ready, exp);
    endtask

    initial begin
        int w;
        rst_n = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        thr_pos = 10'd90; thr_neg = 10'd20; res_ready = 1'b0;
        req_valid6 = '0; req_data6 = '0; req_last6 = '0;
        thr_pos6 = 6'd40; thr_neg6 = 6'd10; res_ready6 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_req_ready", req_ready, 0);
        check("rst_pc_a", pc_a, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_id", res_id, 0);
        check("rst_res_sum", res_sum, 0);
        check("rst_res_trit", res_trit, 0);

        // Overflow: 34 + 34 in a 6-bit accumulator.
        req_valid6 = 2'b01;
        req_data6[33:0] = {34{1'b1}};
        w = 0;
        while (!req_ready6[0] && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("ovf_ready", req_ready6[0], 1);
        @(negedge clk);
        req_last6 = 2'b01;
        @(negedge clk);
        req_valid6 = '0; req_last6 = '0;
        w = 0;
        while (!res_valid6 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("ovf_valid", res_valid6, 1);
`ifdef POPCOUNT_TNN_SCHED_SAT_EN
        check("ovf_sum", res_sum6, 63);
        check("ovf_trit", res_trit6, 2'b01);
`else
        check("ovf_sum", res_sum6, 4);
        check("ovf_trit", res_trit6, 2'b11);
`endif
        res_ready6 = 1'b1;
        @(negedge clk);
        res_ready6 = 1'b0;

        // Basic: 3 x 34 = 102; a threshold change after grant must not matter.
        thr_pos = 10'd90; thr_neg = 10'd20;
        put_beat(0, {34{1'b1}}, 1'b0, w);
        check("arb_latency", w, 1);
        thr_pos = 10'd200;
        put_beat(0, {34{1'b1}}, 1'b0, w);
        check("run_throughput", w, 0);
        put_beat(0, {34{1'b1}}, 1'b1, w);
        finish_pkt("basic", 0, 102, 2'b01);

        // Stall bubble: 6 ones, three idle cycles, then 1 one.
        thr_pos = 10'd90; thr_neg = 10'd20;
        put_beat(2, 34'h3_0000_000F, 1'b0, w);
        repeat (3) @(negedge clk);
        put_beat(2, 34'h0_0000_0001, 1'b1, w);
        finish_pkt("stall", 2, 7, 2'b11);

        // Trit boundaries with a 5-ones single-beat packet.
        thr_pos = 10'd90; thr_neg = 10'd5;
        put_beat(1, 34'h1F, 1'b1, w);
        finish_pkt("trit_neg", 1, 5, 2'b11);
        thr_pos = 10'd6; thr_neg = 10'd4;
        put_beat(1, 34'h1F, 1'b1, w);
        finish_pkt("trit_zero", 1, 5, 2'b00);
        thr_pos = 10'd5; thr_neg = 10'd5;
        put_beat(1, 34'h1F, 1'b1, w);
        finish_pkt("trit_pos", 1, 5, 2'b01);

        // Backpressure: result held while another requester waits.
        thr_pos = 10'd90; thr_neg = 10'd20;
        put_beat(2, 34'hFF, 1'b1, w);
        check("bp_lat_t1", res_valid, 0);
        @(negedge clk);
        req_valid[0] = 1'b1; req_data[33:0] = 34'h1; req_last[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", res_valid, 1);
            check("bp_sum", res_sum, 8);
            check("bp_trit", res_trit, 2'b11);
            check("bp_id", res_id, 2);
            check("bp_req_ready", req_ready, 0);
            @(negedge clk);
        end
        get_result("bp", 2, 8, 2'b11);
        put_beat(0, 34'h1, 1'b1, w);
        finish_pkt("bp_next", 0, 1, 2'b11);

        // Reset during RUN discards the packet.
        put_beat(3, {34{1'b1}}, 1'b0, w);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_ready", req_ready, 0);
        check("mid_rst_pc_a", pc_a, 0);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_res_sum", res_sum, 0);
        check("mid_rst_res_trit", res_trit, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("mid_rst_no_result", res_valid, 0);
        check("mid_rst_idle_ready", req_ready, 0);

        // Round robin from reset: 1, then 3, then 1 again.
        thr_pos = 10'd90; thr_neg = 10'd0;
        req_data[34*1 +: 34] = 34'h3;
        req_data[34*3 +: 34] = 34'h7;
        req_last  = 4'b1010;
        req_valid = 4'b1010;
        wait_grant("rr_gnt_1", 4'b0010);
        @(negedge clk);
        req_data[34*1 +: 34] = 34'hF;
        finish_pkt("rr_1", 1, 2, 2'b00);
        wait_grant("rr_gnt_3", 4'b1000);
        @(negedge clk);
        req_valid[3] = 1'b0; req_last[3] = 1'b0;
        finish_pkt("rr_3", 3, 3, 2'b00);
        wait_grant("rr_gnt_1b", 4'b0010);
        @(negedge clk);
        req_valid[1] = 1'b0; req_last[1] = 1'b0;
        finish_pkt("rr_1b", 1, 4, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/popcount_tnn_sched.md
# popcount_tnn_sched

Sequencing and arbitration controller for one shared 34-input popcount unit (exact or approximate `popcount34_*` variant) in a printed ternary-neuron layer. Up to `NREQ` requesters each stream a packet of 34-bit activation beats. The block grants the popcount unit to one requester at a time in round-robin order and accumulates the per-beat counts into a neuron sum. It thresholds the sum into a trit and returns sum, trit and requester ID over a valid/ready result channel.

## Interface

**Parameters**
- `NREQ`, 4 — number of requesters, 2..8.
- `ACC_W`, 10 — accumulator and threshold width, at least 6.
- `ID_W`, `$clog2(NREQ)` — width of the result ID.

**Ports**
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `req_valid` in NREQ — beat valid, one bit per requester.
- `req_ready` out NREQ — beat accepted; at most one bit high.
- `req_data` in 34*NREQ — beat data; requester i occupies bits [34i+33:34i].
- `req_last` in NREQ — marks the final beat of a packet.
- `thr_pos` in ACC_W — positive threshold.
- `thr_neg` in ACC_W — negative threshold.
- `pc_a` out 34 — registered operand driven to the external popcount unit.
- `pc_cnt` in 6 — combinational popcount of `pc_a`.
- `res_valid` out 1 — result valid.
- `res_ready` in 1 — result accepted.
- `res_id` out ID_W — index of the requester that owns the result.
- `res_sum` out ACC_W — accumulated count.
- `res_trit` out 2 — 01 = +1, 11 = −1, 00 = 0.

## Operation

**State machine (IDLE, RUN, DRAIN, EMIT)**
- **IDLE**
  - All `req_ready` low.
  - If any `req_valid` is high, select the first valid index at or after `rr_ptr`, searching upward with wrap.
  - Store that index as `gnt`, clear `acc`, latch `thr_pos`/`thr_neg`, then go to RUN.
  - Wrong-slot `req_valid` pulses in IDLE are ignored.
- **RUN**
  - `req_ready[gnt]` = 1; all other ready bits are 0.
  - A beat is accepted when `req_valid[gnt]` and `req_ready[gnt]` are both high. On acceptance, `pc_a` <= that beat.
  - If no beat is accepted, `pc_a` <= 0, which contributes a count of 0.
  - Every cycle in RUN and DRAIN: `acc` <= `acc` + `pc_cnt`.
  - If the accepted beat has `req_last` set, go to DRAIN.
- **DRAIN**
  - `req_ready` all low.
  - Compute `s` = `acc` + `pc_cnt`.
  - Register `res_sum` <= `s` and `res_id` <= `gnt`.
  - Register `res_trit`: 01 if `s` ≥ latched `thr_pos`; else 11 if `s` ≤ latched `thr_neg`; else 00. The positive check takes priority.
  - Set `pc_a` <= 0, `rr_ptr` <= `gnt`+1 (mod NREQ), then go to EMIT.
- **EMIT**
  - `res_valid` = 1, and the result fields are held stable.
  - On `res_valid` && `res_ready`, go to IDLE.

**Rules**
- The grant is held for the whole packet; other requesters wait regardless of their valid.
- Thresholds are unsigned. Changes to `thr_pos`/`thr_neg` after the grant have no effect until the next packet.
- A single-beat packet (first beat carries `req_last`) is legal.
- A requester that drops `req_valid` mid-packet stalls RUN indefinitely. There is no timeout.

## Timing

- **Reset values:** state = IDLE, `req_ready` = 0, `pc_a` = 0, `acc` = 0, `rr_ptr` = 0, `res_valid` = 0, `res_id` = 0, `res_sum` = 0, `res_trit` = 00.
- **Reset mid-operation:** an in-flight packet is discarded without a result; the requester must resend it.
- **Arbitration:** one cycle in IDLE from a valid request to `req_ready` high.
- **Throughput:** one beat per cycle while in RUN.
- **Latency:** last beat accepted in cycle t → `res_valid` high in cycle t+2.
- **Back-to-back grants:**
  - EMIT handshake in cycle u → IDLE in u+1 → next `req_ready` in u+2.
  - Minimum packet-to-packet spacing is therefore 4 overhead cycles.
- **Ready independence:** `req_ready` is a function of state and `gnt` only. It never depends combinationally on `req_valid`.
- **External popcount timing:** `pc_cnt` is sampled in the cycle after `pc_a` is loaded, so the popcount path is a single-cycle combinational path.

## Configuration

Macro: `POPCOUNT_TNN_SCHED_SAT_EN`.
- **Defined:** every `acc` update and the DRAIN sum saturate at 2^ACC_W−1.
- **Undefined:** `acc` and the DRAIN sum wrap modulo 2^ACC_W.

## Test plan

- **Basic accumulation:** requester 0 sends 3 beats of all-ones (34 each), `thr_pos`=90, `thr_neg`=20. Required: `res_sum`=102, `res_trit`=01, `res_id`=0, `res_valid` high 2 cycles after the last beat.
- **Round-robin:** requesters 1 and 3 are both valid from reset. Grants go 1 then 3, then 1 again if it re-requests; requester 3 is never skipped.
- **Stall bubble:** 2-beat packet with 0x3_0000_000F, then `req_valid` low 3 cycles, then 0x0_0000_0001 as last. Required: `res_sum`=7; the idle cycles add 0.
- **Negative and zero trit:** 1-beat packet of 5 ones. `thr_neg`=5 gives `res_trit`=11. `thr_neg`=4, `thr_pos`=6 gives 00. `thr_pos`=`thr_neg`=5 gives 01.
- **Overflow:** `ACC_W`=6, 2 beats of 34 ones. With the macro defined, `res_sum`=63; without it, `res_sum`=4.
- **Backpressure and reset:**
  - Hold `res_ready`=0 for 5 cycles: outputs stay stable and all `req_ready` stay 0.
  - Assert `rst_n` low during RUN: outputs return to reset values, and no result is produced for the aborted packet.
